alu_res_arbiter: RTL and testbench

- Round-robin arbiter between the ALU functional units (adder, subtractor, logic unit, …) that share the single FIFO_OUT write port.
- Each unit holds a valid result `{id, carry, data}` until acknowledged; this block selects one, writes it into FIFO_OUT and returns the per-unit written pulse (the `sum_written` input of each unit).
- Also broadcasts the FIFO_OUT room indication (`ready_f_res`) to all units.

---
 rtl/alu_res_arbiter.sv | 119 +++++++++++
 tb/tb_alu_res_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_res_arbiter.sv
// alu_res_arbiter
//   Round-robin arbiter that lets several ALU functional units share the
//   single FIFO_OUT write port. Each unit presents {id, carry, data} with a
//   valid bit and holds it until it sees its res_written pulse.
//
//   Sequence per grant: IDLE (pick + latch) -> WRITE (strobe once FIFO has
//   room) -> ACK (one-hot pulse to the winner, advance rr pointer) -> IDLE.
//
// Ports
//   clk, rst_n   : clock, synchronous active-low reset
//   req_valid    : per-unit result valid
//   req_data     : unit i result at [i*RES_W +: RES_W]
//   res_written  : one-hot, one-cycle ack to the served unit
//   fifo_full    : FIFO_OUT cannot take a write this cycle
//   fifo_wr      : FIFO_OUT write strobe
//   fifo_wdata   : FIFO_OUT write data (latched at grant)
//   ready_f_res  : registered !fifo_full, broadcast to all units
//   grant_idx    : unit currently being served
//   busy         : arbiter not in IDLE
module alu_res_arbiter #(
  parameter  int DATA_SIZE = 16,
  parameter  int ID_SIZE   = 8,
  parameter  int NUM_REQ   = 4,
  localparam int RES_W     = DATA_SIZE + 1 + ID_SIZE,
  localparam int PTR_W     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*RES_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       res_written,
  input  logic                     fifo_full,
  output logic                     fifo_wr,
  output logic [RES_W-1:0]         fifo_wdata,
  output logic                     ready_f_res,
  output logic [PTR_W-1:0]         grant_idx,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0] grant_nxt;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_found;
  logic [RES_W-1:0] wdata_nxt;

  // First valid requester scanning upward from rr_ptr with wrap-around.
  always_comb begin
    int j;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!pick_found && req_valid[j]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      fifo_wdata  <= '0;
      ready_f_res <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      grant_idx   <= grant_nxt;
      fifo_wdata  <= wdata_nxt;
      ready_f_res <= !fifo_full;
    end
  end

  // Strobes decode from the registered state. The write strobe is also
  // qualified by fifo_full so it can never fire into a full FIFO; the
  // state simply parks in WRITE until room appears.
  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    grant_nxt   = grant_idx;
    wdata_nxt   = fifo_wdata;
    fifo_wr     = 1'b0;
    res_written = '0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (pick_found) begin
          grant_nxt = pick_idx;
          wdata_nxt = req_data[pick_idx*RES_W +: RES_W];
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (!fifo_full) begin
          fifo_wr   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        res_written[grant_idx] = 1'b1;
        rr_ptr_nxt = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_res_arbiter.sv
module tb_alu_res_arbiter;
  localparam int DATA_SIZE = 16;
  localparam int ID_SIZE   = 8;
  localparam int NUM_REQ   = 4;
  localparam int RES_W     = DATA_SIZE + 1 + ID_SIZE;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*RES_W-1:0] req_data;
  logic [NUM_REQ-1:0]       res_written;
  logic                     fifo_full;
  logic                     fifo_wr;
  logic [RES_W-1:0]         fifo_wdata;
  logic                     ready_f_res;
  logic [1:0]               grant_idx;
  logic                     busy;

  alu_res_arbiter #(.DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE), .NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .res_written(res_written), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_wdata(fifo_wdata), .ready_f_res(ready_f_res), .grant_idx(grant_idx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             idx;
    logic [RES_W-1:0] data;
  } exp_t;

  exp_t exp_wr[$];
  int   exp_ack[$];
  int   checks = 0;
  int   failures = 0;
  logic [RES_W-1:0] dv[NUM_REQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [RES_W-1:0] mk(input logic [7:0] id, input logic c, input logic [15:0] d);
    return {id, c, d};
  endfunction

  task automatic load_data();
    req_data = {dv[3], dv[2], dv[1], dv[0]};
  endtask

  task automatic expect_unit(input int i);
    exp_t e;
    e.idx  = i;
    e.data = dv[i];
    exp_wr.push_back(e);
    exp_ack.push_back(i);
  endtask

  // Units drop their valid as soon as their ack is visible.
  task automatic tick();
    @(negedge clk);
    req_valid = req_valid & ~res_written;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Scoreboard monitor: samples late in each cycle, well away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (fifo_wr) begin
        chk("wr_while_full", {31'd0, fifo_full}, 32'd0);
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", {7'd0, fifo_wdata}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_wr.pop_front();
          chk("wr_data", {7'd0, fifo_wdata}, {7'd0, e.data});
          chk("wr_grant", {30'd0, grant_idx}, e.idx);
        end
      end
      if (res_written != '0) begin
        if (exp_ack.size() == 0) begin
          chk("unexpected_ack", {28'd0, res_written}, 32'd0);
        end else begin
          int a;
          a = exp_ack.pop_front();
          chk("ack_onehot", {28'd0, res_written}, 32'd1 << a);
        end
      end
    end
  end

  initial begin
    int stamps[4];
    int cnt;
    logic [RES_W-1:0] held;

    dv[0] = mk(8'h10, 1'b0, 16'hA000);
    dv[1] = mk(8'h5A, 1'b1, 16'h1234);
    dv[2] = mk(8'h22, 1'b1, 16'hFFFF);
    dv[3] = mk(8'h33, 1'b0, 16'h0001);
    load_data();
    rst_n = 1'b0; req_valid = '0; fifo_full = 1'b0;

    // ---- reset state
    ticks(2);
    chk("rst_res_written", {28'd0, res_written}, 32'd0);
    chk("rst_fifo_wr", {31'd0, fifo_wr}, 32'd0);
    chk("rst_wdata", {7'd0, fifo_wdata}, 32'd0);
    chk("rst_grant", {30'd0, grant_idx}, 32'd0);
    chk("rst_ready", {31'd0, ready_f_res}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", {31'd0, ready_f_res}, 32'd1);

    // ---- 1: single request on unit 1, latency
    req_valid = 4'b0010; expect_unit(1);
    tick();
    chk("t1_wr_n1", {31'd0, fifo_wr}, 32'd1);
    chk("t1_wdata", {7'd0, fifo_wdata}, 32'h00B5_1234);
    tick();
    chk("t1_ack_n2", {28'd0, res_written}, 32'b0010);
    chk("t1_wr_off", {31'd0, fifo_wr}, 32'd0);
    tick();
    chk("t1_busy_n3", {31'd0, busy}, 32'd0);

    // ---- 2: all four requesting from a fresh pointer -> order 0,1,2,3
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) expect_unit(i);
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (fifo_wr && cnt < 4) begin stamps[cnt] = c; cnt++; end
    end
    chk("t2_write_count", cnt, 32'd4);
    for (int i = 1; i < 4; i++) chk("t2_spacing", stamps[i] - stamps[i-1], 32'd3);

    // ---- 4: serve unit 2, then units 0 and 3 -> 3 first, then 0
    req_valid = 4'b0100; expect_unit(2);
    ticks(4);
    req_valid = 4'b1001; expect_unit(3); expect_unit(0);
    ticks(8);
    chk("t4_drained", {28'd0, req_valid}, 32'd0);

    // ---- 3: FIFO full stall for 5 WRITE cycles (pointer is at 1 -> unit 0 wins)
    fifo_full = 1'b1; req_valid = 4'b0001; expect_unit(0);
    tick();
    held = fifo_wdata;
    chk("t3_ready_low", {31'd0, ready_f_res}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t3_no_wr", {31'd0, fifo_wr}, 32'd0);
      chk("t3_wdata_stable", {7'd0, fifo_wdata}, {7'd0, held});
      chk("t3_busy", {31'd0, busy}, 32'd1);
      if (i < 4) tick();
    end
    fifo_full = 1'b0;
    #1;
    chk("t3_wr_on_room", {31'd0, fifo_wr}, 32'd1);
    chk("t3_ready_lags", {31'd0, ready_f_res}, 32'd0);
    tick();
    chk("t3_ack", {28'd0, res_written}, 32'b0001);
    chk("t3_ready_follows", {31'd0, ready_f_res}, 32'd1);
    tick();
    chk("t3_idle", {31'd0, busy}, 32'd0);

    // ---- 5: reset while stalled in WRITE; request is abandoned
    fifo_full = 1'b1; req_valid = 4'b0010;
    tick();
    chk("t5_in_write", {31'd0, busy}, 32'd1);
    rst_n = 1'b0; req_valid = '0;
    tick();
    chk("t5_rst_wr", {31'd0, fifo_wr}, 32'd0);
    chk("t5_rst_ack", {28'd0, res_written}, 32'd0);
    chk("t5_rst_wdata", {7'd0, fifo_wdata}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_ready", {31'd0, ready_f_res}, 32'd0);
    rst_n = 1'b1; fifo_full = 1'b0;
    tick();
    chk("t5_no_late_ack", {28'd0, res_written}, 32'd0);
    req_valid = 4'b0001; expect_unit(0);
    ticks(4);

    // ---- 6: winner drops valid while stalled; latched data still written
    fifo_full = 1'b1; req_valid = 4'b1000; expect_unit(3);
    tick();
    req_valid = '0;
    dv[3] = mk(8'hEE, 1'b1, 16'hDEAD);
    load_data();
    tick();
    fifo_full = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_stays_idle", {31'd0, busy}, 32'd0);
    end

    chk("wr_queue_empty", exp_wr.size(), 32'd0);
    chk("ack_queue_empty", exp_ack.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
